alu_vec_sequencer: RTL
======================

// Module: alu_vec_sequencer
// PURPOSE
//  Multi-cycle controller directly upstream of the ALU. On a start pulse it streams COUNT operand pairs out
//  of a single-port synchronous RAM, presents them to the ALU with a fixed opcode, and writes each
//  alu_out back to a destination region of the same RAM. It pulses done when the last write is issued.
// PARAMETERS
//  ADDR_W  8   RAM word-address width; all address arithmetic is modulo 2^ADDR_W
//  DATA_W  32  RAM/ALU data width
//  OP_W    5   ALU opcode width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       request; sampled only in IDLE
//  op         in   OP_W    ALU opcode for the whole run; latched on accepted start
//  base_a     in   ADDR_W  first address of operand A vector; latched
//  base_b     in   ADDR_W  first address of operand B vector; latched
//  base_dst   in   ADDR_W  first address of result vector; latched
//  count      in   ADDR_W  element count (0..2^ADDR_W-1); latched
//  busy       out  1       high from the cycle after an accepted start until done
//  done       out  1       one-cycle pulse at run end
//  ram_addr   out  ADDR_W  RAM address (registered)
//  ram_we     out  1       RAM write enable (registered)
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, valid one cycle after its address
//  alu_a      out  DATA_W  ALU operand A (registered)
//  alu_b      out  DATA_W  ALU operand B (registered)
//  alu_op     out  OP_W    ALU opcode (registered)
//  alu_out    in   DATA_W  combinational ALU result
// BEHAVIOUR
//  - Reset (asynchronous, any state): state=IDLE, index=0. busy, done, ram_we, ram_addr, alu_a, alu_b
//    and alu_op are all 0. A write in flight is dropped.
//  - FSM states: IDLE, RD_A, RD_B, CAP, WR, FIN. Index i counts from 0 to count-1.
//  - IDLE: start=1 latches op/bases/count and sets i=0. count==0 goes to FIN; otherwise to RD_A.
//  - RD_A: ram_addr<=base_a+i. Go to RD_B.
//  - RD_B: ram_addr<=base_b+i and alu_a<=ram_rdata (the A word). Go to CAP.
//  - CAP: alu_b<=ram_rdata and alu_op<=op_latched. Go to WR.
//  - WR: ram_we<=1, ram_addr<=base_dst+i, ram_wdata<=alu_out. The RAM commits on the next edge.
//    If i==count-1 go to FIN, else i<=i+1 and go to RD_A. ram_we is high for exactly one cycle per element.
//  - FIN: done=1 for one cycle, busy=0, then IDLE. A start asserted in FIN is ignored.
//  - Throughput is 4 cycles per element. Latency from start to done is 4*count+2 cycles.
//  - start while busy is ignored, and the latched parameters do not change.
//  - Address wrap: base+i overflowing 2^ADDR_W wraps to 0 silently.
//  - Overlapping src/dst regions are allowed. Element i is fully read before its own write, so in-place
//    operation (base_dst==base_a) is exact.
//  - alu_op/alu_a/alu_b hold their last values in IDLE.
// CONFIGURATION
//  ALU_SEQ_OPCHK_EN defined:
//   - An accepted start with op > 6 (outside NOP..NOR) goes straight to FIN.
//   - done and err (an extra 1-bit output, reset 0) pulse together; no RAM access occurs.
//  ALU_SEQ_OPCHK_EN undefined:
//   - There is no err port, and any op is passed through unchecked.
// STRUCTURE
//  - Shared package alu_pkg: ALU opcode constants (NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOR=6),
//    OP_W, and the FSM state encoding.
//  - One sub-module, alu_vec_addr_gen, holds i, the last-element compare and the three base+i adders.
//  - FSM and datapath registers stay in the top level.
// TESTING
//  1. RAM[0..3]={1,2,3,4}, RAM[16..19]={10,20,30,40}; op=ADD, a=0, b=16, dst=32, count=4
//     -> RAM[32..35]={11,22,33,44}; done exactly 18 cycles after start.
//  2. count=0, op=SUB -> done 2 cycles after start, ram_we never asserted.
//  3. base_a=254, base_b=0x80, dst=0xFE, count=3, op=XOR -> addresses wrap 254,255,0.
//     Results are correct in place.
//  4. Assert rst_n=0 in the WR state of element 2 of a 4-element run
//     -> all outputs are 0 immediately, RAM[dst+2] is unwritten, and a new start works.
//  5. Re-pulse start with different params mid-run -> ignored; the original run completes unchanged.
//  6. ALU_SEQ_OPCHK_EN with op=7 -> err and done pulse 2 cycles after start, no ram_we.
//     With the macro undefined, op=7 runs count iterations.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, opcode width and sequencer FSM encoding
//   Opcodes NOP..NOR are the ALU's defined operations; anything above ALU_NOR is
//   outside the defined set (checked only when ALU_SEQ_OPCHK_EN is defined).
package alu_pkg;

  localparam int OP_W = 5;

  localparam int unsigned ALU_NOP = 0;
  localparam int unsigned ALU_ADD = 1;
  localparam int unsigned ALU_SUB = 2;
  localparam int unsigned ALU_AND = 3;
  localparam int unsigned ALU_OR  = 4;
  localparam int unsigned ALU_XOR = 5;
  localparam int unsigned ALU_NOR = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_CAP  = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/alu_vec_addr_gen.sv
// rtl/alu_vec_addr_gen.sv - element index, last-element compare and base+index adders
//   clk, rst_n          clock, asynchronous active-low reset
//   clr, inc            index clear (run start) / advance (after each write)
//   base_a/b/dst, count latched run parameters
//   addr_a/b/dst        base + next index (index value after the coming edge)
//   last                current index is the final element (index == count-1)
module alu_vec_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_dst,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_dst,
  output logic              last
);

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;

  // Adders run on the next index so the top can register the address that
  // belongs to the state being entered. Sums wrap modulo 2^ADDR_W.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign addr_a   = base_a + idx_d;
  assign addr_b   = base_b + idx_d;
  assign addr_dst = base_dst + idx_d;
  assign last     = (idx_q == (count - ADDR_W'(1)));

endmodule

// File: rtl/alu_vec_sequencer.sv
// rtl/alu_vec_sequencer.sv - streams operand pairs from RAM through the ALU and writes results back
//   Optional macro ALU_SEQ_OPCHK_EN: rejects op > NOR at start (adds err output).
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, op, base_a, base_b,
//   base_dst, count             run request and parameters, latched on accepted start
//   busy, done, err             run status; done/err are one-cycle pulses
//   ram_addr, ram_we, ram_wdata,
//   ram_rdata                   single-port synchronous RAM (read data one cycle after address)
//   alu_a, alu_b, alu_op,
//   alu_out                     registered ALU operands, combinational ALU result
module alu_vec_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_dst,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
`ifdef ALU_SEQ_OPCHK_EN
  output logic              err,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out
);

  import alu_pkg::*;

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic              start_ok;
  logic              idx_clr;
  logic              idx_inc;
  logic              op_bad;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [ADDR_W-1:0] base_dst_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_dst;
  logic              last;

`ifdef ALU_SEQ_OPCHK_EN
  logic bad_q;
  assign op_bad = (32'(op) > ALU_NOR);
`else
  assign op_bad = 1'b0;
`endif

  alu_vec_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (idx_clr),
    .inc      (idx_inc),
    .base_a   (base_a_q),
    .base_b   (base_b_q),
    .base_dst (base_dst_q),
    .count    (count_q),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .addr_dst (addr_dst),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          idx_clr  = 1'b1;
          state_d  = (count == '0 || op_bad) ? S_FIN : S_RD_A;
        end
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: state_d = S_CAP;
      S_CAP:  state_d = S_WR;
      S_WR: begin
        if (last) begin
          state_d = S_FIN;
        end else begin
          idx_inc = 1'b1;
          state_d = S_RD_A;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Each state's RAM address is registered on entry so the synchronous RAM
  // returns the word during the following state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      op_q       <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      base_dst_q <= '0;
      count_q    <= '0;
    end else begin
      busy   <= (state_d != S_IDLE);
      done   <= (state_q == S_FIN);
      ram_we <= (state_d == S_WR);
      if (start_ok) begin
        op_q       <= op;
        base_a_q   <= base_a;
        base_b_q   <= base_b;
        base_dst_q <= base_dst;
        count_q    <= count;
      end
      if (start_ok && state_d == S_RD_A) begin
        ram_addr <= base_a;
      end else begin
        case (state_q)
          S_RD_A: ram_addr <= addr_b;
          S_CAP:  ram_addr <= addr_dst;
          S_WR:   if (!last) ram_addr <= addr_a;
          default: ;
        endcase
      end
      if (state_q == S_RD_B) begin
        alu_a <= ram_rdata;
      end
      if (state_q == S_CAP) begin
        alu_b  <= ram_rdata;
        alu_op <= op_q;
      end
    end
  end

`ifdef ALU_SEQ_OPCHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (start_ok) begin
        bad_q <= op_bad;
      end
      err <= (state_q == S_FIN) && bad_q;
    end
  end
`endif

  assign ram_wdata = alu_out;

endmodule
